// File: rtl/clock_set_controller.sv
// ---------------------------------------------------------------------------
// clock_set_controller
//
// Purpose:
//   Time-of-day keeper with a three-state set FSM (RUN / SET_HOUR /
//   SET_MINUTE). In RUN, secondTick pulses advance the time. In the SET
//   modes, incButton edits the selected field, and blink flashes that field.
//
// Configuration macro:
//   TWELVE_HOUR_EN - when defined, hours run 1..12 and reset to 12.
//                    When it is not defined, hours run 0..23 and reset to 0.
//
// Parameters:
//   TICKS_PER_MINUTE - secondTick pulses per minute (legal range 2..63)
//
// Ports:
//   clock          in   system clock; all state changes on its rising edge
//   resetN         in   asynchronous active-low reset
//   secondTick     in   one-cycle pulse, one per second
//   modeButton     in   one-cycle pulse; advances the mode
//   incButton      in   one-cycle pulse; increments the field being set
//   minutes        out  current minute (0..59)
//   hours          out  current hour
//   mode           out  00 RUN, 01 SET_HOUR, 10 SET_MINUTE
//   minuteTick     out  one-cycle pulse after each minute rollover in RUN
//   halfHourToggle out  inverts each time minutes reaches 30 or 0 in RUN
//   blink          out  blink level for the field being set (0 in RUN)
// ---------------------------------------------------------------------------
module clock_set_controller #(
    parameter int TICKS_PER_MINUTE = 60
) (
    input  logic       clock,
    input  logic       resetN,
    input  logic       secondTick,
    input  logic       modeButton,
    input  logic       incButton,
    output logic [5:0] minutes,
    output logic [4:0] hours,
    output logic [1:0] mode,
    output logic       minuteTick,
    output logic       halfHourToggle,
    output logic       blink
);

    typedef enum logic [1:0] {
        ST_RUN        = 2'b00,
        ST_SET_HOUR   = 2'b01,
        ST_SET_MINUTE = 2'b10,
        ST_ILLEGAL    = 2'b11
    } state_t;

    localparam logic [5:0] LP_SEC_LAST = 6'(TICKS_PER_MINUTE - 1);
    localparam logic [5:0] LP_MIN_LAST = 6'd59;

`ifdef TWELVE_HOUR_EN
    localparam logic [4:0] LP_HOUR_RESET = 5'd12;
    localparam logic [4:0] LP_HOUR_FIRST = 5'd1;
    localparam logic [4:0] LP_HOUR_LAST  = 5'd12;
`else
    localparam logic [4:0] LP_HOUR_RESET = 5'd0;
    localparam logic [4:0] LP_HOUR_FIRST = 5'd0;
    localparam logic [4:0] LP_HOUR_LAST  = 5'd23;
`endif

    state_t     r_state, w_state_next;
    logic [5:0] r_sec_count, w_sec_count_next;
    logic [5:0] r_minutes, w_minutes_next;
    logic [4:0] r_hours, w_hours_next;
    logic       r_minute_tick, w_minute_tick_next;
    logic       r_half_hour, w_half_hour_next;
    logic       r_blink, w_blink_next;

    // Wrapped increments shared by the RUN and SET paths.
    logic       w_min_wrap;
    logic [5:0] w_min_inc;
    logic [4:0] w_hour_inc;

    assign w_min_wrap = (r_minutes == LP_MIN_LAST);
    assign w_min_inc  = w_min_wrap ? 6'd0 : r_minutes + 6'd1;
    assign w_hour_inc = (r_hours == LP_HOUR_LAST) ? LP_HOUR_FIRST : r_hours + 5'd1;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_state       <= ST_RUN;
            r_sec_count   <= 6'd0;
            r_minutes     <= 6'd0;
            r_hours       <= LP_HOUR_RESET;
            r_minute_tick <= 1'b0;
            r_half_hour   <= 1'b0;
            r_blink       <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_sec_count   <= w_sec_count_next;
            r_minutes     <= w_minutes_next;
            r_hours       <= w_hours_next;
            r_minute_tick <= w_minute_tick_next;
            r_half_hour   <= w_half_hour_next;
            r_blink       <= w_blink_next;
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_sec_count_next   = r_sec_count;
        w_minutes_next     = r_minutes;
        w_hours_next       = r_hours;
        w_minute_tick_next = 1'b0;
        w_half_hour_next   = r_half_hour;
        w_blink_next       = r_blink;

        case (r_state)
            ST_RUN: begin
                w_blink_next = 1'b0;
                if (modeButton) begin
                    // A secondTick that coincides with leaving RUN is dropped.
                    w_state_next     = ST_SET_HOUR;
                    w_sec_count_next = 6'd0;
                    w_blink_next     = 1'b1;
                end else if (secondTick) begin
                    if (r_sec_count == LP_SEC_LAST) begin
                        w_sec_count_next   = 6'd0;
                        w_minute_tick_next = 1'b1;
                        w_minutes_next     = w_min_inc;
                        if (w_min_wrap) begin
                            w_hours_next = w_hour_inc;
                        end
                        if (w_min_inc == 6'd30 || w_min_inc == 6'd0) begin
                            w_half_hour_next = ~r_half_hour;
                        end
                    end else begin
                        w_sec_count_next = r_sec_count + 6'd1;
                    end
                end
            end

            ST_SET_HOUR: begin
                w_sec_count_next = 6'd0;
                if (modeButton) begin
                    // The mode change takes priority; a simultaneous inc is lost.
                    w_state_next = ST_SET_MINUTE;
                    w_blink_next = 1'b1;
                end else begin
                    if (incButton) begin
                        w_hours_next = w_hour_inc;
                    end
                    if (secondTick) begin
                        w_blink_next = ~r_blink;
                    end
                end
            end

            ST_SET_MINUTE: begin
                w_sec_count_next = 6'd0;
                if (modeButton) begin
                    // Returning to RUN restarts from a full minute.
                    w_state_next = ST_RUN;
                    w_blink_next = 1'b0;
                end else begin
                    if (incButton) begin
                        w_minutes_next = w_min_inc;
                    end
                    if (secondTick) begin
                        w_blink_next = ~r_blink;
                    end
                end
            end

            default: begin
                w_state_next     = ST_RUN;
                w_sec_count_next = 6'd0;
                w_blink_next     = 1'b0;
            end
        endcase
    end

    assign minutes        = r_minutes;
    assign hours          = r_hours;
    assign mode           = r_state;
    assign minuteTick     = r_minute_tick;
    assign halfHourToggle = r_half_hour;
    assign blink          = r_blink;

endmodule

// File: tb/tb_clock_set_controller.sv
module tb_clock_set_controller;

    typedef struct packed {
        logic [1:0] mode;
        logic [5:0] min;
        logic [4:0] hr;
        logic       mt;
        logic       hht;
        logic       bl;
    } out_t;

    typedef struct {
        logic mb;
        logic ib;
        logic st;
        out_t exp;
    } vec_t;

`ifdef TWELVE_HOUR_EN
    localparam int HR_RST = 12;
    localparam int HR_PRE = 0;   // increments needed to reach the last hour
`else
    localparam int HR_RST = 0;
    localparam int HR_PRE = 23;
`endif

    logic       clock = 1'b0;
    logic       resetN = 1'b0;
    logic       secondTick = 1'b0;
    logic       modeButton = 1'b0;
    logic       incButton = 1'b0;
    logic [5:0] minutes;
    logic [4:0] hours;
    logic [1:0] mode;
    logic       minuteTick;
    logic       halfHourToggle;
    logic       blink;

    int   n_cmp = 0;
    int   n_bad = 0;
    out_t exp_q[$];
    vec_t vecs[11];

    clock_set_controller #(.TICKS_PER_MINUTE(60)) dut (
        .clock(clock), .resetN(resetN), .secondTick(secondTick),
        .modeButton(modeButton), .incButton(incButton),
        .minutes(minutes), .hours(hours), .mode(mode),
        .minuteTick(minuteTick), .halfHourToggle(halfHourToggle), .blink(blink)
    );

    always #5 clock = ~clock;

    // Hour value after n increments from the reset hour.
    function automatic logic [4:0] hr_after(input int n);
`ifdef TWELVE_HOUR_EN
        return 5'(((11 + n) % 12) + 1);
`else
        return 5'(n % 24);
`endif
    endfunction

    function automatic out_t mk(input int md, input int mn, input int hr, input int mt, input int hh, input int bl);
        out_t o;
        o.mode = 2'(md); o.min = 6'(mn); o.hr = 5'(hr);
        o.mt = 1'(mt); o.hht = 1'(hh); o.bl = 1'(bl);
        return o;
    endfunction

    task automatic check_sb(input string name);
        out_t e, a;
        a = {mode, minutes, hours, minuteTick, halfHourToggle, blink};
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL %s: scoreboard empty, got mode=%0d min=%0d hr=%0d", name, mode, minutes, hours);
        end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
                n_bad++;
                $display("FAIL %s: got mode=%0d min=%0d hr=%0d mt=%0b hht=%0b bl=%0b, want mode=%0d min=%0d hr=%0d mt=%0b hht=%0b bl=%0b",
                         name, a.mode, a.min, a.hr, a.mt, a.hht, a.bl, e.mode, e.min, e.hr, e.mt, e.hht, e.bl);
            end else begin
                $display("ok   %s: mode=%0d min=%0d hr=%0d mt=%0b hht=%0b bl=%0b", name, a.mode, a.min, a.hr, a.mt, a.hht, a.bl);
            end
        end
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Called at a falling edge: drive one cycle of inputs, return at the next falling edge.
    task automatic cyc(input logic mb, input logic ib, input logic st);
        modeButton = mb; incButton = ib; secondTick = st;
        @(posedge clock);
        #1;
        modeButton = 1'b0; incButton = 1'b0; secondTick = 1'b0;
        @(negedge clock);
    endtask

    // Assert reset between edges and check outputs before the next rising edge.
    task automatic do_reset(input string name);
        #2 resetN = 1'b0;
        #1;
        exp_q.push_back(mk(0, 0, HR_RST, 0, 0, 0));
        check_sb(name);
        @(negedge clock);
        resetN = 1'b1;
        exp_q.push_back(mk(0, 0, HR_RST, 0, 0, 0));
        check_sb({name, "_held"});
    endtask

    task automatic ticks_no_mt(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            cyc(0, 0, 1);
            check_val(name, minuteTick, 0);
        end
    endtask

    initial begin
        int mt_cnt;
        int hh_cnt;
        logic hh_prev;

        @(negedge clock);
        do_reset("reset_init");

        // mb ib st -> mode min hr(n incs) mt hht bl
        vecs[0]  = '{0, 1, 0, mk(0, 0, hr_after(0), 0, 0, 0)};
        vecs[1]  = '{1, 0, 0, mk(1, 0, hr_after(0), 0, 0, 1)};
        vecs[2]  = '{0, 1, 0, mk(1, 0, hr_after(1), 0, 0, 1)};
        vecs[3]  = '{0, 0, 1, mk(1, 0, hr_after(1), 0, 0, 0)};
        vecs[4]  = '{0, 1, 1, mk(1, 0, hr_after(2), 0, 0, 1)};
        vecs[5]  = '{1, 1, 0, mk(2, 0, hr_after(2), 0, 0, 1)};
        vecs[6]  = '{0, 1, 0, mk(2, 1, hr_after(2), 0, 0, 1)};
        vecs[7]  = '{0, 0, 1, mk(2, 1, hr_after(2), 0, 0, 0)};
        vecs[8]  = '{1, 0, 1, mk(0, 1, hr_after(2), 0, 0, 0)};
        vecs[9]  = '{0, 0, 1, mk(0, 1, hr_after(2), 0, 0, 0)};
        vecs[10] = '{0, 1, 0, mk(0, 1, hr_after(2), 0, 0, 0)};

        for (int i = 0; i < 11; i++) begin
            exp_q.push_back(vecs[i].exp);
            cyc(vecs[i].mb, vecs[i].ib, vecs[i].st);
            check_sb($sformatf("vec%0d", i));
        end

        // One tick already counted after returning to RUN; 59 more complete the minute.
        ticks_no_mt("restart_no_mt", 58);
        exp_q.push_back(mk(0, 2, hr_after(2), 1, 0, 0));
        cyc(0, 0, 1);
        check_sb("restart_minute");
        exp_q.push_back(mk(0, 2, hr_after(2), 0, 0, 0));
        cyc(0, 0, 0);
        check_sb("mt_one_cycle");

        // Tick coinciding with leaving RUN is dropped and secCount cleared.
        ticks_no_mt("pre_leave", 30);
        exp_q.push_back(mk(1, 2, hr_after(2), 0, 0, 1));
        cyc(1, 0, 1);
        check_sb("leave_run_tick");
        cyc(1, 0, 0);
        exp_q.push_back(mk(0, 2, hr_after(2), 0, 0, 0));
        cyc(1, 0, 0);
        check_sb("back_to_run");
        ticks_no_mt("after_return", 59);
        exp_q.push_back(mk(0, 3, hr_after(2), 1, 0, 0));
        cyc(0, 0, 1);
        check_sb("full_minute");

        // 60 ticks from reset -> one minute, exactly one pulse.
        do_reset("reset_a");
        mt_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            cyc(0, 0, 1);
            if (minuteTick) mt_cnt++;
        end
        cyc(0, 0, 0);
        if (minuteTick) mt_cnt++;
        check_val("one_min_minutes", minutes, 1);
        check_val("one_min_pulses", mt_cnt, 1);
        ticks_no_mt("seccount_zero", 59);
        cyc(0, 0, 1);
        check_val("seccount_zero_mt", minuteTick, 1);

        // Preload the last minute of the day, then roll over.
        do_reset("reset_b");
        cyc(1, 0, 0);
        for (int i = 0; i < HR_PRE; i++) cyc(0, 1, 0);
        cyc(1, 0, 0);
        for (int i = 0; i < 59; i++) cyc(0, 1, 0);
        exp_q.push_back(mk(0, 59, hr_after(HR_PRE), 0, 0, 0));
        cyc(1, 0, 0);
        check_sb("preload_2359");
        ticks_no_mt("rollover_wait", 59);
        exp_q.push_back(mk(0, 0, hr_after(HR_PRE + 1), 1, 1, 0));
        cyc(0, 0, 1);
        check_sb("day_rollover");

        // One hour of ticks -> two half-hour toggles and 60 pulses.
        do_reset("reset_c");
        mt_cnt = 0; hh_cnt = 0; hh_prev = halfHourToggle;
        for (int i = 0; i < 3600; i++) begin
            cyc(0, 0, 1);
            if (minuteTick) mt_cnt++;
            if (halfHourToggle != hh_prev) hh_cnt++;
            hh_prev = halfHourToggle;
        end
        check_val("hour_mt_count", mt_cnt, 60);
        check_val("hour_hht_count", hh_cnt, 2);
        exp_q.push_back(mk(0, 0, hr_after(1), 0, 0, 0));
        cyc(0, 0, 0);
        check_sb("hour_end");

        // SET_MINUTE wrap 59 -> 0 with no carry and no toggle.
        do_reset("reset_d");
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        for (int i = 0; i < 58; i++) cyc(0, 1, 0);
        exp_q.push_back(mk(2, 59, HR_RST, 0, 0, 1));
        cyc(0, 1, 0);
        check_sb("setmin_59");
        exp_q.push_back(mk(2, 0, HR_RST, 0, 0, 1));
        cyc(0, 1, 0);
        check_sb("setmin_wrap");

        // mode and inc together in SET_HOUR at 5.
        do_reset("reset_e");
        cyc(1, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 0);
        exp_q.push_back(mk(2, 0, 5, 0, 0, 1));
        cyc(1, 1, 0);
        check_sb("mode_inc_same");

        // Mid-cycle reset in SET_HOUR at 7 discards the edit.
        do_reset("reset_f");
        cyc(1, 0, 0);
        for (int i = 0; i < 6; i++) cyc(0, 1, 0);
        exp_q.push_back(mk(1, 0, 7, 0, 0, 1));
        cyc(0, 1, 0);
        check_sb("sethour_7");
        do_reset("reset_mid_set");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/clock_set_controller.md
CLOCK_SET_CONTROLLER -- requirements
Module: clock_set_controller

Interface
REQ-001 The block SHALL have parameter TICKS_PER_MINUTE, default 60, meaning the number of secondTick pulses per minute (legal range 2..63).
REQ-002 The block SHALL have port clock, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port resetN, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port secondTick, input, 1 bit: a single-cycle pulse, synchronous to clock, one per second.
REQ-005 The block SHALL have port modeButton, input, 1 bit: a single-cycle synchronous pulse that advances the mode.
REQ-006 The block SHALL have port incButton, input, 1 bit: a single-cycle synchronous pulse that increments the selected field.
REQ-007 The block SHALL have port minutes, output, 6 bits: the current minute.
REQ-008 The block SHALL have port hours, output, 5 bits: the current hour.
REQ-009 The block SHALL have port mode, output, 2 bits: 00 RUN, 01 SET_HOUR, 10 SET_MINUTE.
REQ-010 The block SHALL have port minuteTick, output, 1 bit: a one-cycle pulse on each minute rollover in RUN.
REQ-011 The block SHALL have port halfHourToggle, output, 1 bit: a level that inverts on each half-hour boundary in RUN.
REQ-012 The block SHALL have port blink, output, 1 bit: a display blink level for the field being set.

Function
REQ-013 The FSM SHALL cycle RUN -> SET_HOUR -> SET_MINUTE -> RUN, one step per modeButton pulse; the mode register changes on the edge that samples the pulse.
REQ-014 The encoding 11 SHALL return to RUN on the next clock edge.
REQ-015 In RUN, each secondTick SHALL increment the internal 6-bit secCount.
REQ-016 In RUN, on a secondTick with secCount == TICKS_PER_MINUTE-1, the block SHALL set secCount to 0, increment minutes, and assert minuteTick on the following cycle only, i.e. one cycle after the edge that sampled secondTick.
REQ-017 Minutes SHALL wrap 59 -> 0 and carry to hours in the same edge.
REQ-018 Hours SHALL wrap 23 -> 0.
REQ-019 In RUN, halfHourToggle SHALL invert on the same edge that minutes becomes 30 or 0.
REQ-020 In SET_HOUR, each incButton pulse SHALL increment hours with wrap and no carry.
REQ-021 In SET_MINUTE, each incButton pulse SHALL increment minutes, wrapping 59 -> 0 with no carry into hours and no halfHourToggle change.
REQ-022 In the SET modes, secondTick SHALL NOT advance time, secCount SHALL be held at 0, and minuteTick SHALL be 0.
REQ-023 In RUN, incButton SHALL be ignored.
REQ-024 If modeButton and incButton are both asserted in the same cycle, only the mode SHALL change; the increment SHALL be discarded.
REQ-025 If secondTick coincides with the modeButton pulse that leaves RUN, the tick SHALL be discarded and secCount SHALL be cleared.
REQ-026 On the SET_MINUTE -> RUN transition, secCount SHALL be cleared so that timing restarts from a full minute.
REQ-027 blink SHALL be 0 in RUN.
REQ-028 In the SET modes, blink SHALL toggle on each secondTick.
REQ-029 blink SHALL be forced to 1 on entry to each SET mode.

Reset
REQ-030 While resetN is low, the block SHALL immediately force: mode = RUN, secCount = 0, minutes = 0, hours = 0 (12 when TWELVE_HOUR_EN is defined), minuteTick = 0, halfHourToggle = 0, blink = 0.
REQ-031 Reset deassertion SHALL be accepted on any cycle; the first secondTick after release SHALL count as secCount 0 -> 1.
REQ-032 Reset asserted in a SET mode SHALL discard partial edits.

Configuration
REQ-033 With macro TWELVE_HOUR_EN defined, hours SHALL range 1..12, wrap 12 -> 1 in both RUN and SET_HOUR, and reset to 12.
REQ-034 Without macro TWELVE_HOUR_EN, hours SHALL range 0..23, wrap 23 -> 0, and reset to 0.
REQ-035 All other behaviour SHALL be identical with or without TWELVE_HOUR_EN.

Verification
REQ-036 Scenario: TICKS_PER_MINUTE=60, release reset, apply 60 secondTicks -> minutes=1, exactly one minuteTick pulse, secCount=0.
REQ-037 Scenario: preload 23:59 via the SET modes, return to RUN, apply 60 ticks -> hours=0, minutes=0, halfHourToggle inverted once (12:59 -> 1:00 with TWELVE_HOUR_EN).
REQ-038 Scenario: run from 00:00 for 3600 ticks -> halfHourToggle inverts exactly twice (at minutes 30 and 0) and 60 minuteTicks are seen.
REQ-039 Scenario: in SET_MINUTE at minutes=59, pulse incButton -> minutes=0, hours unchanged, halfHourToggle unchanged.
REQ-040 Scenario: modeButton and incButton in the same cycle while in SET_HOUR at hours=5 -> mode=SET_MINUTE, hours=5.
REQ-041 Scenario: assert resetN=0 mid-cycle in SET_HOUR with hours=7 -> all outputs reach their reset values before the next clock edge.
